rs_symbol_corrector: RTL and testbench

- Final stage of the RS(15,11) GF(16) decoder.
- Buffers each received 15-symbol codeword while syndrome, key-equation and Chien/Forney stages run.
- Consumes the per-symbol error-value stream from the error-positioning stage and XORs each value into the buffered symbol (GF(16) addition).
- Emits corrected symbols. Two buffer banks (ping-pong) let codeword n+1 be received while codeword n is corrected.

---
 rtl/rs_symbol_corrector.sv | 98 +++++++++
 tb/tb_rs_symbol_corrector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_symbol_corrector.sv
// RS(15,11) final stage: ping-pong codeword buffer that XORs Forney error values into the
// buffered symbols; out_sym follows its accepted err_val by one cycle with no output backpressure.
module rs_symbol_corrector #(
  parameter int N          = 15,
  parameter int K          = 11,
  parameter bit OUT_PARITY = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       in_valid,
  input  logic [3:0] in_sym,
  output logic       in_ready,
  input  logic       err_valid,
  input  logic [3:0] err_val,
  output logic       err_ready,
  output logic       out_valid,
  output logic [3:0] out_sym,
  output logic       out_last,
  output logic [3:0] corr_count
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] EMIT_LAST = OUT_PARITY ? IW'(N - 1) : IW'(K - 1);
  localparam logic [IW-1:0] K_IDX     = IW'(K);

  logic [3:0]    mem [2][N];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [3:0]    run_count;

  logic          wr_fire;
  logic          rd_fire;
  logic          rd_emit;
  logic [3:0]    rd_sym;
  logic [3:0]    next_count;

  assign in_ready   = !full[wr_bank];
  assign err_ready  = full[rd_bank];
  assign wr_fire    = in_valid && in_ready;
  assign rd_fire    = err_valid && err_ready;
  assign rd_sym     = mem[rd_bank][rd_idx] ^ err_val;
  assign rd_emit    = OUT_PARITY || (rd_idx < K_IDX);
  assign next_count = run_count + {3'b000, err_val != 4'h0};

  // Buffer contents survive reset; only the bookkeeping is cleared.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_fire) begin
      mem[wr_bank][wr_idx] <= in_sym;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      run_count  <= 4'h0;
      out_valid  <= 1'b0;
      out_sym    <= 4'h0;
      out_last   <= 1'b0;
      corr_count <= 4'h0;
    end else begin
      out_valid <= rd_fire && rd_emit;
      out_sym   <= (rd_fire && rd_emit) ? rd_sym : 4'h0;
      out_last  <= rd_fire && (rd_idx == EMIT_LAST);

      // A completing write and a completing read always touch different banks.
      if (wr_fire) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

      if (rd_fire) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          corr_count    <= next_count;
          run_count     <= 4'h0;
        end else begin
          rd_idx    <= rd_idx + 1'b1;
          run_count <= next_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_symbol_corrector.sv
// Scoreboard bench for rs_symbol_corrector: one instance per OUT_PARITY setting, shared stimulus,
// expected symbols pushed at err accept and popped when the output cycle arrives.
module tb_rs_symbol_corrector;
  localparam int N = 15;
  localparam int K = 11;

  typedef struct packed {
    logic [3:0] sym;
    logic       last;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_sym = 4'h0;
  logic       err_valid = 1'b0;
  logic [3:0] err_val = 4'h0;

  logic       in_ready0, err_ready0, out_valid0, out_last0;
  logic [3:0] out_sym0, corr_count0;
  logic       in_ready1, err_ready1, out_valid1, out_last1;
  logic [3:0] out_sym1, corr_count1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rs_symbol_corrector #(.N(N), .K(K), .OUT_PARITY(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready0),
    .err_valid(err_valid), .err_val(err_val), .err_ready(err_ready0),
    .out_valid(out_valid0), .out_sym(out_sym0), .out_last(out_last0),
    .corr_count(corr_count0)
  );

  rs_symbol_corrector #(.N(N), .K(K), .OUT_PARITY(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready1),
    .err_valid(err_valid), .err_val(err_val), .err_ready(err_ready1),
    .out_valid(out_valid1), .out_sym(out_sym1), .out_last(out_last1),
    .corr_count(corr_count1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle on the falling edge.
  logic           mon_en = 1'b0;
  logic [N*4-1:0] cw_q[$];
  logic [N*4-1:0] wbuf = '0;
  logic [N*4-1:0] rcw;
  int             widx = 0;
  int             ridx = 0;
  logic [3:0]     run = 4'h0;
  logic [3:0]     corr_stage = 4'h0;
  logic [3:0]     m_corr = 4'h0;
  exp_t           q0[$];
  exp_t           q1[$];
  exp_t           e0;
  logic           pend0 = 1'b0, pend1 = 1'b0, pend_corr = 1'b0;
  logic           wacc, racc;
  logic [3:0]     s;

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (pend_corr) m_corr = corr_stage;
        check_val("in_ready0", in_ready0, cw_q.size() < 2);
        check_val("in_ready1", in_ready1, cw_q.size() < 2);
        check_val("err_ready0", err_ready0, cw_q.size() > 0);
        check_val("err_ready1", err_ready1, cw_q.size() > 0);
        if (pend0) begin
          e0 = q0.pop_front();
          check_val("out0", {out_valid0, out_last0, out_sym0}, {1'b1, e0.last, e0.sym});
        end else begin
          check_val("idle0", {out_valid0, out_last0, out_sym0}, 32'h0);
        end
        if (pend1) begin
          e0 = q1.pop_front();
          check_val("out1", {out_valid1, out_last1, out_sym1}, {1'b1, e0.last, e0.sym});
        end else begin
          check_val("idle1", {out_valid1, out_last1, out_sym1}, 32'h0);
        end
        check_val("corr0", corr_count0, m_corr);
        check_val("corr1", corr_count1, m_corr);
        pend0 = 1'b0;
        pend1 = 1'b0;
        pend_corr = 1'b0;
        if (RESET) begin
          cw_q.delete();
          q0.delete();
          q1.delete();
          widx = 0;
          ridx = 0;
          run = 4'h0;
          m_corr = 4'h0;
        end else begin
          wacc = in_valid && (cw_q.size() < 2);
          racc = err_valid && (cw_q.size() > 0);
          if (racc) begin
            rcw = cw_q[0];
            s = rcw[ridx*4 +: 4] ^ err_val;
            if (err_val != 4'h0) run = run + 4'h1;
            if (ridx < K) begin
              q0.push_back('{sym: s, last: (ridx == K-1)});
              pend0 = 1'b1;
            end
            q1.push_back('{sym: s, last: (ridx == N-1)});
            pend1 = 1'b1;
            if (ridx == N-1) begin
              corr_stage = run;
              pend_corr = 1'b1;
              run = 4'h0;
              ridx = 0;
              rcw = cw_q.pop_front();
            end else begin
              ridx++;
            end
          end
          if (wacc) begin
            wbuf[widx*4 +: 4] = in_sym;
            if (widx == N-1) begin
              cw_q.push_back(wbuf);
              widx = 0;
            end else begin
              widx++;
            end
          end
        end
      end
    end
  end

  // Drivers start and end just after a rising edge; acceptance is judged at the falling edge.
  task automatic send_syms(input logic [N*4-1:0] cw, input int n);
    int waits;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sym = cw[i*4 +: 4];
      waits = 0;
      @(negedge CLK);
      while (!in_ready0 && waits < 200) begin
        @(negedge CLK);
        waits++;
      end
      if (waits >= 200) begin
        check_val("wr_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    in_sym = 4'h0;
  endtask

  task automatic send_err(input logic [N*4-1:0] ev, input int n);
    int waits;
    for (int i = 0; i < n; i++) begin
      err_valid = 1'b1;
      err_val = ev[i*4 +: 4];
      waits = 0;
      @(negedge CLK);
      while (!err_ready0 && waits < 200) begin
        @(negedge CLK);
        waits++;
      end
      if (waits >= 200) begin
        check_val("err_timeout", 32'd0, 32'd1);
        err_valid = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
    end
    err_valid = 1'b0;
    err_val = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [N*4-1:0] seq_cw();
    logic [N*4-1:0] c;
    for (int i = 0; i < N; i++) c[i*4 +: 4] = 4'(i + 1);
    return c;
  endfunction

  function automatic logic [N*4-1:0] rand_vec(input bit sparse);
    logic [N*4-1:0] c;
    for (int i = 0; i < N; i++) begin
      if (!sparse || $urandom_range(0, 2) == 0) c[i*4 +: 4] = 4'($urandom_range(1, 15));
      else c[i*4 +: 4] = 4'h0;
    end
    return c;
  endfunction

  logic [N*4-1:0] ev;
  logic [N*4-1:0] rcw_a [4];
  logic [N*4-1:0] rev_a [4];

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    check_val("rst_in_ready", in_ready0, 32'd1);
    check_val("rst_err_ready", err_ready0, 32'd0);
    check_val("rst_out_valid", out_valid0, 32'd0);
    check_val("rst_corr", corr_count0, 32'd0);
    @(posedge CLK);
    #1;

    // Clean codeword
    send_syms(seq_cw(), N);
    send_err('0, N);
    check_val("clean_corr", corr_count0, 32'd0);

    // Two errors at indices 2 and 9
    ev = '0;
    ev[2*4 +: 4] = 4'h3;
    ev[9*4 +: 4] = 4'h8;
    send_syms(seq_cw(), N);
    send_err(ev, N);
    check_val("two_err_corr", corr_count0, 32'd2);

    // Ping-pong fill with no correction
    send_syms({N{4'h5}}, N);
    send_syms({N{4'hA}}, N);
    idle(2);
    check_val("pp_in_ready_full", in_ready0, 32'd0);
    check_val("pp_err_ready_full", err_ready0, 32'd1);
    send_err('0, N);
    check_val("pp_in_ready_freed", in_ready0, 32'd1);
    send_err('0, N);

    // Overlap: write next codeword while correcting the current one
    send_syms(seq_cw(), N);
    rcw_a[0] = rand_vec(1'b0);
    rev_a[0] = rand_vec(1'b1);
    fork
      send_syms(rcw_a[0], N);
      send_err(rev_a[0], N);
    join
    send_err(rand_vec(1'b1), N);

    // Parity symbol error at the last index
    ev = '0;
    ev[14*4 +: 4] = 4'h1;
    send_syms(seq_cw(), N);
    send_err(ev, N);
    check_val("par_corr1", corr_count1, 32'd1);
    check_val("par_corr0", corr_count0, 32'd1);

    // Reset in the middle of a write and a correction
    send_syms(seq_cw(), N);
    fork
      send_syms({N{4'h7}}, 7);
      send_err('0, 3);
    join
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_val("mid_rst_out_valid", out_valid0, 32'd0);
    check_val("mid_rst_in_ready", in_ready0, 32'd1);
    check_val("mid_rst_err_ready", err_ready0, 32'd0);
    @(posedge CLK);
    #1;
    ev = '0;
    ev[0 +: 4] = 4'h1;
    send_syms(seq_cw(), N);
    send_err(ev, N);
    check_val("post_rst_corr", corr_count0, 32'd1);

    // Pipelined random traffic
    for (int r = 0; r < 4; r++) begin
      rcw_a[r] = rand_vec(1'b0);
      rev_a[r] = rand_vec(1'b1);
    end
    send_syms(rcw_a[0], N);
    for (int r = 1; r < 4; r++) begin
      fork
        send_syms(rcw_a[r], N);
        send_err(rev_a[r-1], N);
      join
    end
    send_err(rev_a[3], N);

    idle(4);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
